// File: rtl/cmsdk_mcu_pin_filter.sv
// Pad input conditioning: 2-flop sync, per-bit debounce, edge pulses, sticky interrupt flags.
// Latency: pad_in->sync_out 2 edges, ->filt_out 3 edges in bypass; int_status 1 edge after its set condition.
// Backpressure: none; every input is sampled each cycle.
module cmsdk_mcu_pin_filter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] filt_en,
    input  logic [CNT_W-1:0] debounce_len,
    input  logic [WIDTH-1:0] int_en,
    input  logic [WIDTH-1:0] int_type,
    input  logic [WIDTH-1:0] int_pol,
    input  logic [WIDTH-1:0] int_clr,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] int_status,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] filt_dly_q, filt_dly_d;
    logic [WIDTH-1:0] int_status_q, int_status_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] lvl_set;

    always_comb begin
        sync1_d    = pad_in;
        sync2_d    = sync1_q;
        filt_dly_d = filt_q;
        filt_d     = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!filt_en[i]) begin
                filt_d[i] = sync2_q[i];
            end else if (sync2_q[i] != filt_q[i]) begin
                // The >= compare both bounds the counter and commits at once
                // if debounce_len is lowered below the running count.
                if (cnt_q[i] >= debounce_len) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        rise     = filt_q & ~filt_dly_q;
        fall     = ~filt_q & filt_dly_q;
        edge_set = int_en & ~int_type & ((int_pol & rise) | (~int_pol & fall));
        // A level source is masked for the clear cycle so the flag visibly
        // drops for one cycle and re-arms while the level persists.
        lvl_set  = int_en & int_type & ~(filt_q ^ int_pol) & ~int_clr;
        int_status_d = edge_set | lvl_set | (int_status_q & ~int_clr);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            filt_q       <= '0;
            filt_dly_q   <= '0;
            int_status_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            filt_q       <= filt_d;
            filt_dly_q   <= filt_dly_d;
            int_status_q <= int_status_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sync_out   = sync2_q;
    assign filt_out   = filt_q;
    assign rise_pulse = rise;
    assign fall_pulse = fall;
    assign int_status = int_status_q;
    assign irq        = |int_status_q;

endmodule

// File: tb/tb_cmsdk_mcu_pin_filter.sv
// Directed bench for cmsdk_mcu_pin_filter: stimulus queues timed expectations,
// a negedge monitor compares them in the cycle they fall due.
module tb_cmsdk_mcu_pin_filter;

    localparam int SEL_SYNC = 0, SEL_FILT = 1, SEL_RISE = 2, SEL_FALL = 3, SEL_STAT = 4, SEL_IRQ = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pad_in, filt_en, int_en, int_type, int_pol, int_clr;
    logic [3:0]  debounce_len;
    logic [15:0] sync_out, filt_out, rise_pulse, fall_pulse, int_status;
    logic        irq;

    typedef struct {
        int          cyc;
        string       nm;
        int          sel;
        logic [15:0] m;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc        = 0;
    int   vectors    = 0;
    int   miscompares = 0;

    cmsdk_mcu_pin_filter #(.WIDTH(16), .CNT_W(4)) dut (
        .HCLK(clk), .HRESET(rst), .pad_in(pad_in), .filt_en(filt_en),
        .debounce_len(debounce_len), .int_en(int_en), .int_type(int_type),
        .int_pol(int_pol), .int_clr(int_clr), .sync_out(sync_out),
        .filt_out(filt_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .int_status(int_status), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pick(input int sel);
        case (sel)
            SEL_SYNC: return sync_out;
            SEL_FILT: return filt_out;
            SEL_RISE: return rise_pulse;
            SEL_FALL: return fall_pulse;
            SEL_STAT: return int_status;
            default:  return {15'b0, irq};
        endcase
    endfunction

    always @(negedge clk) begin
        logic [15:0] act;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                act = pick(sb[k].sel);
                vectors++;
                if ((act & sb[k].m) !== (sb[k].v & sb[k].m)) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d got=%h want=%h mask=%h",
                             sb[k].nm, cyc, act & sb[k].m, sb[k].v & sb[k].m, sb[k].m);
                end
                sb.delete(k);
            end
        end
    end

    task automatic expect_at(input int d, input string nm, input int sel,
                             input logic [15:0] m, input logic [15:0] v);
        exp_t e;
        e.cyc = cyc + d;
        e.nm  = nm;
        e.sel = sel;
        e.m   = m;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pad_in = 16'hFFFF;
        filt_en = '0; int_en = '0; int_type = '0; int_pol = '0; int_clr = '0;
        debounce_len = 4'd0;
        step(3);

        // reset holds everything low even with all pins high
        expect_at(0, "rst_sync", SEL_SYNC, 16'hFFFF, 16'h0000);
        expect_at(0, "rst_filt", SEL_FILT, 16'hFFFF, 16'h0000);
        expect_at(0, "rst_rise", SEL_RISE, 16'hFFFF, 16'h0000);
        expect_at(0, "rst_stat", SEL_STAT, 16'hFFFF, 16'h0000);
        expect_at(0, "rst_irq",  SEL_IRQ,  16'h0001, 16'h0000);
        step(1);

        // release with pins high: normal path, one rise pulse
        rst = 1'b0;
        expect_at(2, "rel_sync", SEL_SYNC, 16'hFFFF, 16'hFFFF);
        expect_at(2, "rel_filt_early", SEL_FILT, 16'hFFFF, 16'h0000);
        expect_at(3, "rel_filt", SEL_FILT, 16'hFFFF, 16'hFFFF);
        expect_at(3, "rel_rise", SEL_RISE, 16'hFFFF, 16'hFFFF);
        expect_at(4, "rel_rise_end", SEL_RISE, 16'hFFFF, 16'h0000);
        step(6);
        pad_in = '0;
        step(6);

        // bypass latency on bit 0
        pad_in[0] = 1'b1;
        expect_at(1, "byp_sync_early", SEL_SYNC, 16'h0001, 16'h0000);
        expect_at(2, "byp_sync", SEL_SYNC, 16'h0001, 16'h0001);
        expect_at(2, "byp_filt_early", SEL_FILT, 16'h0001, 16'h0000);
        expect_at(3, "byp_filt", SEL_FILT, 16'h0001, 16'h0001);
        expect_at(2, "byp_rise_early", SEL_RISE, 16'h0001, 16'h0000);
        expect_at(3, "byp_rise", SEL_RISE, 16'h0001, 16'h0001);
        expect_at(4, "byp_rise_end", SEL_RISE, 16'h0001, 16'h0000);
        step(6);
        pad_in[0] = 1'b0;
        expect_at(3, "byp_fall", SEL_FALL, 16'h0001, 16'h0001);
        expect_at(4, "byp_fall_end", SEL_FALL, 16'h0001, 16'h0000);
        step(6);

        // debounce bit 3, len 4: 4-cycle glitch rejected, 5-cycle level accepted
        debounce_len = 4'd4;
        filt_en[3] = 1'b1;
        step(1);
        pad_in[3] = 1'b1;
        expect_at(5, "glitch_filt5", SEL_FILT, 16'h0008, 16'h0000);
        expect_at(7, "glitch_filt7", SEL_FILT, 16'h0008, 16'h0000);
        expect_at(9, "glitch_filt9", SEL_FILT, 16'h0008, 16'h0000);
        step(4);
        pad_in[3] = 1'b0;
        step(8);
        pad_in[3] = 1'b1;
        expect_at(6, "deb_filt_early", SEL_FILT, 16'h0008, 16'h0000);
        expect_at(7, "deb_filt", SEL_FILT, 16'h0008, 16'h0008);
        expect_at(7, "deb_rise", SEL_RISE, 16'h0008, 16'h0008);
        expect_at(8, "deb_rise_end", SEL_RISE, 16'h0008, 16'h0000);
        step(10);
        pad_in[3] = 1'b0;
        expect_at(6, "deb_fall_early", SEL_FILT, 16'h0008, 16'h0008);
        expect_at(7, "deb_fall", SEL_FALL, 16'h0008, 16'h0008);
        step(10);

        // falling-edge interrupt on bit 5
        int_en[5] = 1'b1; int_type[5] = 1'b0; int_pol[5] = 1'b0;
        pad_in[5] = 1'b1;
        expect_at(5, "edge_rise_noset", SEL_STAT, 16'h0020, 16'h0000);
        step(6);
        pad_in[5] = 1'b0;
        expect_at(3, "edge_fallp", SEL_FALL, 16'h0020, 16'h0020);
        expect_at(3, "edge_stat_early", SEL_STAT, 16'h0020, 16'h0000);
        expect_at(4, "edge_stat", SEL_STAT, 16'h0020, 16'h0020);
        expect_at(4, "edge_irq", SEL_IRQ, 16'h0001, 16'h0001);
        step(6);
        int_clr[5] = 1'b1;
        expect_at(1, "edge_clr", SEL_STAT, 16'h0020, 16'h0000);
        expect_at(1, "edge_clr_irq", SEL_IRQ, 16'h0001, 16'h0000);
        step(1);
        int_clr[5] = 1'b0;
        pad_in[5] = 1'b1;
        step(6);
        pad_in[5] = 1'b0;
        expect_at(3, "coin_pre", SEL_STAT, 16'h0020, 16'h0000);
        expect_at(4, "coin_setwins", SEL_STAT, 16'h0020, 16'h0020);
        expect_at(6, "coin_hold", SEL_STAT, 16'h0020, 16'h0020);
        step(3);
        int_clr[5] = 1'b1;
        step(1);
        int_clr[5] = 1'b0;
        step(3);
        int_en[5] = 1'b0;
        expect_at(2, "en_off_keeps", SEL_STAT, 16'h0020, 16'h0020);
        step(3);
        int_clr[5] = 1'b1;
        expect_at(1, "en_off_clr", SEL_STAT, 16'h0020, 16'h0000);
        step(1);
        int_clr[5] = 1'b0;
        step(2);

        // high-level interrupt on bit 7
        int_en[7] = 1'b1; int_type[7] = 1'b1; int_pol[7] = 1'b1;
        pad_in[7] = 1'b1;
        expect_at(3, "lvl_early", SEL_STAT, 16'h0080, 16'h0000);
        expect_at(4, "lvl_set", SEL_STAT, 16'h0080, 16'h0080);
        step(6);
        int_clr[7] = 1'b1;
        expect_at(1, "lvl_drop", SEL_STAT, 16'h0080, 16'h0000);
        expect_at(2, "lvl_reset", SEL_STAT, 16'h0080, 16'h0080);
        step(1);
        int_clr[7] = 1'b0;
        step(3);
        int_en[7] = 1'b0;
        int_clr[7] = 1'b1;
        expect_at(1, "lvl_dis_clr", SEL_STAT, 16'h0080, 16'h0000);
        expect_at(3, "lvl_dis_stay", SEL_STAT, 16'h0080, 16'h0000);
        expect_at(3, "lvl_dis_irq", SEL_IRQ, 16'h0001, 16'h0000);
        step(1);
        int_clr[7] = 1'b0;
        step(3);

        // reset mid-count on bit 9, len 15
        debounce_len = 4'd15;
        filt_en[9] = 1'b1;
        pad_in[9] = 1'b1;
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_at(0, "mid_rst_sync", SEL_SYNC, 16'hFFFF, 16'h0000);
        expect_at(0, "mid_rst_filt", SEL_FILT, 16'hFFFF, 16'h0000);
        expect_at(0, "mid_rst_rise", SEL_RISE, 16'hFFFF, 16'h0000);
        expect_at(0, "mid_rst_fall", SEL_FALL, 16'hFFFF, 16'h0000);
        expect_at(0, "mid_rst_stat", SEL_STAT, 16'hFFFF, 16'h0000);
        expect_at(0, "mid_rst_irq",  SEL_IRQ,  16'h0001, 16'h0000);
        expect_at(17, "restart_early", SEL_FILT, 16'h0200, 16'h0000);
        expect_at(18, "restart_commit", SEL_FILT, 16'h0200, 16'h0200);
        step(22);

        // lower debounce_len mid-count on bit 11
        debounce_len = 4'd10;
        filt_en[11] = 1'b1;
        pad_in[11] = 1'b1;
        expect_at(8, "lower_early", SEL_FILT, 16'h0800, 16'h0000);
        expect_at(9, "lower_commit", SEL_FILT, 16'h0800, 16'h0800);
        step(8);
        debounce_len = 4'd2;
        step(4);

        step(3);
        if (sb.size() != 0) begin
            foreach (sb[k]) begin
                miscompares++;
                $display("FAIL %s never checked: due cyc=%0d now=%0d", sb[k].nm, sb[k].cyc, cyc);
            end
        end
        if (vectors < 12) begin
            miscompares++;
            $display("FAIL only %0d vectors applied", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule

// File: doc/cmsdk_mcu_pin_filter.md
CMSDK_MCU_PIN_FILTER -- requirements
Module: cmsdk_mcu_pin_filter

Purpose: input conditioning stage downstream of the pin multiplexer. It takes raw pad-side input bits (p0_in / p1_in) and produces synchronised, debounced levels, edge pulses and a sticky interrupt for the GPIO and timer blocks.

Interface
REQ-001 Parameter WIDTH, default 16, number of pin bits handled.
REQ-002 Parameter CNT_W, default 4, width of each per-bit debounce counter.
REQ-003 Port HCLK, input, 1, sole clock; all state SHALL be updated on its rising edge.
REQ-004 Port HRESET, input, 1, reset; synchronous and active-high.
REQ-005 Port pad_in, input, WIDTH, asynchronous pin levels from the pin mux.
REQ-006 Port filt_en, input, WIDTH, per-bit debounce enable (1 = filter, 0 = bypass).
REQ-007 Port debounce_len, input, CNT_W, stability length shared by all filtered bits.
REQ-008 Port int_en, input, WIDTH, per-bit interrupt enable.
REQ-009 Port int_type, input, WIDTH, per-bit interrupt type (0 = edge, 1 = level).
REQ-010 Port int_pol, input, WIDTH, per-bit polarity (1 = rising/high, 0 = falling/low).
REQ-011 Port int_clr, input, WIDTH, per-bit single-cycle clear strobe for int_status.
REQ-012 Port sync_out, output, WIDTH, second synchroniser stage.
REQ-013 Port filt_out, output, WIDTH, debounced level (registered).
REQ-014 Port rise_pulse, output, WIDTH, one-cycle rising-edge pulse of filt_out.
REQ-015 Port fall_pulse, output, WIDTH, one-cycle falling-edge pulse of filt_out.
REQ-016 Port int_status, output, WIDTH, sticky per-bit interrupt flags.
REQ-017 Port irq, output, 1, OR-reduction of int_status.

Function
REQ-018 Synchronisation: each bit SHALL pass through a two-flop synchroniser; sync_out is the second stage, so pad_in reaches sync_out two edges later.
REQ-019 Bypass (filt_en[i]=0): filt_out[i] SHALL load sync_out[i] every cycle, giving a total latency of 3 edges from pad_in; cnt[i] SHALL be held at 0.
REQ-020 Filtered path, no change: if filt_en[i]=1 and sync_out[i]==filt_out[i], cnt[i] SHALL clear to 0.
REQ-021 Filtered path, commit: if sync_out[i]!=filt_out[i] and cnt[i]>=debounce_len, filt_out[i] SHALL take sync_out[i] and cnt[i] SHALL clear.
REQ-022 Filtered path, count: if sync_out[i]!=filt_out[i] and cnt[i]<debounce_len, cnt[i] SHALL increment.
REQ-023 Filter consequences:
- A change must persist debounce_len+1 consecutive cycles at sync_out.
- debounce_len=0 is equivalent to bypass.
- A shorter glitch leaves filt_out unchanged.
REQ-024 cnt SHALL never wrap: the >= comparison bounds it. Lowering debounce_len mid-count SHALL commit on the next differing cycle.
REQ-025 Toggling filt_en[i] mid-count SHALL take effect the next cycle. A switch to bypass discards the count.
REQ-026 Edge pulses: a registered copy filt_d of filt_out SHALL be kept.
- rise_pulse = filt_out & ~filt_d
- fall_pulse = ~filt_out & filt_d
- Each is high exactly one cycle, the first cycle filt_out shows the new value.
REQ-027 Set condition, int_type[i]=0 (edge): rise_pulse[i] when int_pol[i]=1; fall_pulse[i] when int_pol[i]=0; gated by int_en[i].
REQ-028 Set condition, int_type[i]=1 (level): filt_out[i]==int_pol[i], gated by int_en[i].
REQ-029 int_status[i] SHALL set on the next edge after its set condition. It SHALL clear on the edge after int_clr[i]=1. Set SHALL win over a simultaneous clear.
REQ-030 A level interrupt SHALL re-set one cycle after a clear while the level persists.
REQ-031 Clearing int_en[i] SHALL NOT clear int_status[i].
REQ-032 irq SHALL be combinational OR of int_status, with no added latency.

Reset
REQ-033 While HRESET=1 at an edge, these SHALL become 0: both synchroniser stages, filt_out, filt_d, all cnt, and int_status. Consequently sync_out, filt_out, rise_pulse, fall_pulse, int_status and irq are all 0.
REQ-034 Reset asserted mid-debounce SHALL abandon the count; no pulse is produced in the reset cycle.
REQ-035 After reset release with a pin held high, filt_out SHALL rise through the normal path and generate one rise_pulse (3 edges in bypass). This is intended behaviour.

Verification
REQ-036 Bypass, filt_en=0, pad_in[0] 0->1 -> sync_out[0] rises after 2 edges, filt_out[0] after 3; rise_pulse[0] high for exactly 1 cycle.
REQ-037 Filter, filt_en[3]=1, debounce_len=4, pad_in[3] high for 4 cycles then low -> filt_out[3] stays 0. Held high for 5 cycles -> filt_out[3] rises after 2+5 edges.
REQ-038 Edge interrupt, int_en[5]=1, int_type=0, int_pol=0, pin falls -> int_status[5] and irq set 1 cycle after fall_pulse[5]. Pulse int_clr[5] -> cleared; a fall coincident with int_clr leaves int_status[5]=1.
REQ-039 Level interrupt, int_type[7]=1, int_pol[7]=1, pin held high, int_clr[7] pulsed -> int_status[7] drops for one cycle then re-sets. With int_en[7]=0 it is not re-set.
REQ-040 Reset mid-count, debounce_len=15, HRESET asserted after 8 stable cycles -> all outputs 0 next edge. After release, the full 16-cycle requirement restarts.
REQ-041 debounce_len lowered from 10 to 2 while cnt=6 -> commit on the next differing cycle with no counter wrap.
